wave_monitor: RTL and testbench

//  Receive-side counterpart of the quarter-wave sine DAC generator.

---
 rtl/wave_monitor.sv | 154 +++++++++++++++
 tb/tb_wave_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wave_monitor.sv
// wave_monitor: receive-side checker for the quarter-wave sine DAC chain.
// Tracks the quadrant of an offset-binary sample stream with hysteresis,
// measures the period between upward crossings and latches per-cycle peaks.
module wave_monitor #(
    parameter int DATA_WIDTH   = 10,
    parameter int MID          = 512,
    parameter int HYST         = 8,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_valid,
    input  logic [DATA_WIDTH-1:0]   sample,
    output logic [1:0]              quadrant,
    output logic                    locked,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic [DATA_WIDTH-1:0]   peak_max,
    output logic [DATA_WIDTH-1:0]   peak_min,
    output logic                    overflow
);

    localparam logic [2:0] S_SEEK = 3'd0;
    localparam logic [2:0] S_Q1   = 3'd1;
    localparam logic [2:0] S_Q2   = 3'd2;
    localparam logic [2:0] S_Q3   = 3'd3;
    localparam logic [2:0] S_Q4   = 3'd4;

    // One extra bit keeps MID+HYST and ext+HYST from wrapping.
    localparam int CW = DATA_WIDTH + 1;
    localparam logic [CW-1:0] TH_HI = CW'(MID + HYST);
    localparam logic [CW-1:0] TH_LO = CW'(MID - HYST);
    localparam logic [CW-1:0] HY    = CW'(HYST);

    localparam logic [PERIOD_WIDTH-1:0] CNT_TOP  = '1;
    localparam logic [PERIOD_WIDTH-1:0] CNT_NEAR = CNT_TOP - PERIOD_WIDTH'(1);

    logic [2:0]              state, state_nx;
    logic [DATA_WIDTH-1:0]   ext, ext_nx;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic                    armed;
    logic                    uc, pmax_ld, pmin_ld;
    logic [CW-1:0]           s_x, e_x;
    logic                    sat;

    assign s_x = {1'b0, sample};
    assign e_x = {1'b0, ext};
    // The increment that would land on the top value is the saturating one.
    assign sat = armed && (cnt == CNT_NEAR);

    function automatic logic [1:0] quad_of(input logic [2:0] s);
        case (s)
            S_Q2:    quad_of = 2'b01;
            S_Q3:    quad_of = 2'b10;
            S_Q4:    quad_of = 2'b11;
            default: quad_of = 2'b00;
        endcase
    endfunction

    // Next-state and extreme tracking; thresholds use the pre-update ext.
    always_comb begin
        state_nx = state;
        ext_nx   = ext;
        uc       = 1'b0;
        pmax_ld  = 1'b0;
        pmin_ld  = 1'b0;
        case (state)
            S_SEEK: begin
                if (s_x >= TH_HI) begin
                    state_nx = S_Q1;
                    ext_nx   = sample;
                end else if (s_x <= TH_LO) begin
                    state_nx = S_Q3;
                    ext_nx   = sample;
                end
            end
            S_Q1: begin
                if (s_x + HY <= e_x) begin
                    state_nx = S_Q2;
                    pmax_ld  = 1'b1;
                end else if (s_x > e_x) begin
                    ext_nx = sample;
                end
            end
            S_Q2: begin
                if (s_x <= TH_LO) begin
                    state_nx = S_Q3;
                    ext_nx   = sample;
                end
            end
            S_Q3: begin
                if (s_x >= e_x + HY) begin
                    state_nx = S_Q4;
                    pmin_ld  = 1'b1;
                end else if (s_x < e_x) begin
                    ext_nx = sample;
                end
            end
            S_Q4: begin
                if (s_x >= TH_HI) begin
                    state_nx = S_Q1;
                    ext_nx   = sample;
                    uc       = 1'b1;
                end
            end
            default: state_nx = S_SEEK;
        endcase
    end

    // Registered FSM, peaks and period measurement, advanced on valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_SEEK;
            ext          <= '0;
            quadrant     <= 2'b00;
            peak_max     <= '0;
            peak_min     <= '0;
            cnt          <= '0;
            armed        <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (sample_valid) begin
                state    <= state_nx;
                ext      <= ext_nx;
                quadrant <= quad_of(state_nx);
                if (pmax_ld) peak_max <= ext;
                if (pmin_ld) peak_min <= ext;
                if (armed) begin
                    if (sat) begin
                        cnt      <= CNT_TOP;
                        overflow <= 1'b1;
                        locked   <= 1'b0;
                        armed    <= 1'b0;
                    end else if (uc) begin
                        period       <= cnt + PERIOD_WIDTH'(1);
                        period_valid <= 1'b1;
                        locked       <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + PERIOD_WIDTH'(1);
                    end
                end else if (uc) begin
                    armed <= 1'b1;
                    cnt   <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_monitor.sv
// tb_wave_monitor: directed checks of quadrant tracking, thresholds,
// period measurement, saturation and asynchronous reset.
module tb_wave_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [9:0]  sample = '0;
    logic [1:0]  quadrant;
    logic        locked;
    logic [15:0] period;
    logic        period_valid;
    logic [9:0]  peak_max;
    logic [9:0]  peak_min;
    logic        overflow;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   pulses = 0;
    int   base   = 0;
    logic trk    = 1'b0;
    logic [1:0] prev_q = 2'b00;

    wave_monitor #(
        .DATA_WIDTH(10), .MID(512), .HYST(8), .PERIOD_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .quadrant(quadrant), .locked(locked), .period(period),
        .period_valid(period_valid), .peak_max(peak_max), .peak_min(peak_min),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Full-scale 512-sample sine, 0..1023.
    function automatic int sine_at(input int n);
        real v;
        int  r;
        v = 511.5 + 511.5 * $sin(6.283185307179586 * real'(n % 512) / 512.0);
        r = $rtoi(v + 0.5);
        if (r < 0) r = 0;
        if (r > 1023) r = 1023;
        return r;
    endfunction

    task automatic feed(input int val, input logic vld);
        logic [40:0] snap;
        logic [1:0]  nq;
        snap = {quadrant, period, peak_max, peak_min, locked, overflow, 1'b0};
        sample = val[9:0];
        sample_valid = vld;
        @(posedge clk);
        #1;
        if (period_valid) pulses++;
        if (!vld)
            check("hold_invalid", {quadrant, period, peak_max, peak_min, locked, overflow, period_valid}, snap);
        if (trk && quadrant != prev_q) begin
            nq = prev_q + 2'd1;
            check("quad_order", quadrant, nq);
            prev_q = quadrant;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_q = 2'b00;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_q"}, quadrant, 2'b00);
        check({tag, "_period"}, period, 16'd0);
        check({tag, "_pmax"}, peak_max, 10'd0);
        check({tag, "_pmin"}, peak_min, 10'd0);
        check({tag, "_flags"}, {locked, period_valid, overflow}, 3'b000);
    endtask

    initial begin
        // Reset state and threshold edges
        do_reset();
        check_reset_vals("rst");
        feed(519, 1'b1); check("seek_519", quadrant, 2'b00);
        feed(511, 1'b1); check("seek_still", quadrant, 2'b00);
        feed(520, 1'b1); check("q1_520", quadrant, 2'b00);
        feed(512, 1'b1); check("q2_entry", quadrant, 2'b01);
        check("pmax_520", peak_max, 10'd520);
        feed(504, 1'b1); check("q3_504", quadrant, 2'b10);
        feed(100, 1'b1); check("q3_100", quadrant, 2'b10);
        feed(107, 1'b1); check("q3_107", quadrant, 2'b10);
        check("pmin_pre", peak_min, 10'd0);
        feed(108, 1'b1); check("q4_108", quadrant, 2'b11);
        check("pmin_100", peak_min, 10'd100);
        check("no_lock_t4", locked, 1'b0);

        // Continuous sine, ends in Q2 of the third cycle
        do_reset();
        trk = 1'b1;
        pulses = 0;
        for (int n = 0; n <= 1224; n++) begin
            feed(sine_at(n), 1'b1);
            if (n == 64)   check("t1_q1", quadrant, 2'b00);
            if (n == 200)  check("t1_q2", quadrant, 2'b01);
            if (n == 320)  check("t1_q3", quadrant, 2'b10);
            if (n == 450)  check("t1_q4", quadrant, 2'b11);
            if (n == 1000) check("t1_prelock", {locked, 8'(pulses)}, {1'b0, 8'd0});
        end
        check("t1_pulses", pulses, 1);
        check("t1_period", period, 16'd512);
        check("t1_locked", locked, 1'b1);
        check("t1_pmax", peak_max, 10'd1023);
        check("t1_pmin", peak_min, 10'd0);
        check("t1_ovf", overflow, 1'b0);
        check("t1_qend", quadrant, 2'b01);

        // Mid-scale noise inside the hysteresis band
        for (int i = 0; i < 2000; i++) feed(508 + (i * 7) % 9, 1'b1);
        check("t3_q", quadrant, 2'b01);
        check("t3_pulses", pulses, 1);
        check("t3_flags", {locked, overflow}, 2'b10);

        // Long constant input saturates the period counter
        for (int i = 0; i < 60000; i++) feed(700, 1'b1);
        check("t5_pre_ovf", {locked, overflow}, 2'b10);
        for (int i = 0; i < 10000; i++) feed(700, 1'b1);
        check("t5_ovf", {locked, overflow}, 2'b01);
        check("t5_period_hold", period, 16'd512);
        base = pulses;
        for (int n = 0; n <= 1100; n++) begin
            feed(sine_at(n), 1'b1);
            if (n == 1000) check("t5_rearm_nopulse", {locked, 8'(pulses - base)}, {1'b0, 8'd0});
        end
        check("t5_pulses", pulses - base, 1);
        check("t5_period", period, 16'd512);
        check("t5_flags", {locked, overflow}, 2'b11);

        // Sine with alternating invalid cycles carrying junk samples
        do_reset();
        pulses = 0;
        for (int n = 0; n <= 1100; n++) begin
            feed(sine_at(n), 1'b1);
            feed(1023 - sine_at(n), 1'b0);
        end
        check("t2_pulses", pulses, 1);
        check("t2_period", period, 16'd512);
        check("t2_locked", locked, 1'b1);
        check("t2_pmax", peak_max, 10'd1023);
        check("t2_pmin", peak_min, 10'd0);

        // Asynchronous reset while in Q3 after lock, then re-lock
        do_reset();
        for (int n = 0; n <= 1855; n++) feed(sine_at(n), 1'b1);
        check("t6_pre_q", quadrant, 2'b10);
        check("t6_pre_lock", locked, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        do_reset();
        pulses = 0;
        for (int n = 0; n <= 1100; n++) begin
            feed(sine_at(n), 1'b1);
            if (n == 600)  check("t6_one_uc", {locked, 8'(pulses)}, {1'b0, 8'd0});
            if (n == 1000) check("t6_prelock", {locked, 8'(pulses)}, {1'b0, 8'd0});
        end
        check("t6_pulses", pulses, 1);
        check("t6_period", period, 16'd512);
        check("t6_locked", locked, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
